// File: rtl/ex_muldiv_unit_pkg.sv
// Shared CPU parameters for the EX-stage multiply/divide unit: word width,
// MULDIV op encodings, FSM state encodings and divide control flags.
package ex_muldiv_unit_pkg;

  localparam int WORD = 32;

  typedef enum logic [2:0] {
    OP_MUL   = 3'd0,
    OP_MULH  = 3'd1,
    OP_MULHU = 3'd2,
    OP_RSVD  = 3'd3,
    OP_DIV   = 3'd4,
    OP_MOD   = 3'd5,
    OP_DIVU  = 3'd6,
    OP_MODU  = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } muldiv_state_e;

  typedef struct packed {
    logic neg_q;     // operand signs differ on a signed divide
    logic neg_r;     // signed divide with negative dividend
    logic want_rem;  // remainder-returning ops select the remainder
    logic dvs_zero;  // divide by zero keeps the all-ones quotient
  } div_ctl_t;

  function automatic logic [WORD-1:0] mag(input logic [WORD-1:0] v, input logic sgn);
    return (sgn && v[WORD-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_div_iter.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module ex_div_iter
  import ex_muldiv_unit_pkg::*;
(
  input  logic [WORD-1:0] rem,
  input  logic            dvd_msb,
  input  logic [WORD-1:0] dvs,
  output logic [WORD-1:0] rem_nxt,
  output logic            q_bit
);

  logic [WORD:0] shifted;
  logic [WORD:0] diff;

  // rem < dvs always holds, so bit WORD of diff is a clean borrow flag
  assign shifted = {rem, dvd_msb};
  assign diff    = shifted - {1'b0, dvs};
  assign q_bit   = ~diff[WORD];
  assign rem_nxt = q_bit ? diff[WORD-1:0] : shifted[WORD-1:0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle MUL/MULH/MULHU/DIV/MOD/DIVU/MODU unit with pipeline stall.
// Optional MULDIV_FAST_DIV_EN: divides with |divisor| > |dividend| finish in one cycle.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [WORD-1:0] src1,
  input  logic [WORD-1:0] src2,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] result
);

  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_ITER - 1);

  muldiv_state_e state, state_nxt;
  muldiv_op_e    op_in, op_q;
  logic          accept, div_sgn, fast_skip, mul_sgn, q_step;
  logic [WORD-1:0] mag1, mag2;
  logic [WORD-1:0] quo_q, rem_q, dvs_q, rem_step;
  logic [WORD-1:0] quo_fix, rem_fix, div_res, mul_res;
  logic [5:0]      cnt;
  div_ctl_t        ctl_q;
  logic [2*WORD-1:0] mul_a, mul_b, prod;
  logic [MUL_LAT-1:0][2*WORD-1:0] prod_pipe;

  assign op_in   = muldiv_op_e'(op);
  assign accept  = (state == S_IDLE) && start && !flush;
  assign div_sgn = !op[1];
  assign mag1    = mag(src1, div_sgn);
  assign mag2    = mag(src2, div_sgn);

`ifdef MULDIV_FAST_DIV_EN
  assign fast_skip = op[2] && (mag2 > mag1);
`else
  assign fast_skip = 1'b0;
`endif

  // Product of the incoming operands enters the pipe on the accept edge and
  // reaches the last stage exactly when MUL has counted MUL_LAT cycles.
  assign mul_sgn = (op_in != OP_MULHU);
  assign mul_a   = {{WORD{mul_sgn & src1[WORD-1]}}, src1};
  assign mul_b   = {{WORD{mul_sgn & src2[WORD-1]}}, src2};
  assign prod    = mul_a * mul_b;
  assign mul_res = (op_q == OP_MUL) ? prod_pipe[MUL_LAT-1][WORD-1:0]
                                    : prod_pipe[MUL_LAT-1][2*WORD-1:WORD];

  ex_div_iter u_div_iter (
    .rem     (rem_q),
    .dvd_msb (quo_q[WORD-1]),
    .dvs     (dvs_q),
    .rem_nxt (rem_step),
    .q_bit   (q_step)
  );

  assign quo_fix = (ctl_q.neg_q && !ctl_q.dvs_zero) ? -quo_q : quo_q;
  assign rem_fix = ctl_q.neg_r ? -rem_q : rem_q;
  assign div_res = ctl_q.want_rem ? rem_fix : quo_fix;

  assign stall_req = accept || (state == S_MUL) || (state == S_DIV) || (state == S_FIX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept) begin
        if (op_in == OP_RSVD || fast_skip) state_nxt = S_DONE;
        else if (op[2])                    state_nxt = S_DIV;
        else                               state_nxt = S_MUL;
      end
      S_MUL:   if (cnt == MUL_LAST) state_nxt = S_DONE;
      S_DIV:   if (cnt == DIV_LAST) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      cnt       <= '0;
      op_q      <= OP_MUL;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      ctl_q     <= '0;
      prod_pipe <= '0;
    end else begin
      prod_pipe[0] <= prod;
      for (int i = 1; i < MUL_LAT; i++) prod_pipe[i] <= prod_pipe[i-1];

      done <= (state_nxt == S_DONE);
      busy <= (state_nxt == S_MUL) || (state_nxt == S_DIV) || (state_nxt == S_FIX);

      if ((state == S_MUL || state == S_DIV) && state_nxt == state) cnt <= cnt + 6'd1;
      else                                                          cnt <= '0;

      if (accept) begin
        op_q           <= op_in;
        quo_q          <= mag1;
        dvs_q          <= mag2;
        rem_q          <= '0;
        ctl_q.neg_q    <= div_sgn && (src1[WORD-1] ^ src2[WORD-1]);
        ctl_q.neg_r    <= div_sgn && src1[WORD-1];
        ctl_q.want_rem <= op[0];
        ctl_q.dvs_zero <= (src2 == '0);
      end else if (state == S_DIV) begin
        rem_q <= rem_step;
        quo_q <= {quo_q[WORD-2:0], q_step};
      end

      // state_nxt is never DONE under flush, so a kill leaves result intact
      if (state_nxt == S_DONE) begin
        unique case (state)
          S_IDLE:  result <= (fast_skip && op[0]) ? src1 : '0;
          S_MUL:   result <= mul_res;
          S_FIX:   result <= div_res;
          default: result <= result;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit (MUL_LAT=2): results, latencies,
// stall window, flush, reserved op, divide-by-zero/overflow and mid-op reset.
module tb_ex_muldiv_unit;

`ifdef MULDIV_FAST_DIV_EN
  localparam int FAST_LAT = 1;
`else
  localparam int FAST_LAT = 34;
`endif
  localparam int MUL_L = 3;
  localparam int DIV_L = 34;

  logic        clk, rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] src1, src2, result;
  logic        stall_req, busy, done;
  int          n_chk, n_pass;

  ex_muldiv_unit #(.MUL_LAT(2), .DIV_ITER(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drive at a negedge (cycle T), hold start through DONE, drop it in IDLE.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int k, stalls;
    bit got;
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b; flush = 1'b0;
    #1;
    stalls = int'(stall_req);
    k = 0;
    got = 1'b0;
    while (!got && k < 100) begin
      @(negedge clk);
      k++;
      if (k == 1 && exp_lat > 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (done) got = 1'b1;
      else      stalls += int'(stall_req);
    end
    chk({tag, "_lat"}, 32'(k), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_stall"}, 32'(stalls), 32'(exp_lat));
    chk({tag, "_stall_done"}, 32'(stall_req), 32'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({tag, "_one_pulse"}, 32'(done), 32'd0);
    chk({tag, "_held"}, result, exp_res);
  endtask

  initial begin
    bit no_done;
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; src1 = '0; src2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    rst_n = 1'b1;

    run_op("mul_7x-3",   3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_L);
    run_op("mulh_min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MUL_L);
    run_op("mulhu_min",  3'd2, 32'h80000000, 32'h80000000, 32'h40000000, MUL_L);
    run_op("mul_min",    3'd0, 32'h80000000, 32'h80000000, 32'h00000000, MUL_L);
    run_op("mulhu_ones", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_L);
    run_op("mulh_ones",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_L);
    run_op("div_-7_2",   3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_L);
    run_op("mod_-7_2",   3'd5, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_L);
    run_op("divu_big",   3'd6, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, DIV_L);
    run_op("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, DIV_L);
    run_op("mod_ovf",    3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, DIV_L);
    run_op("divu_5_0",   3'd6, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, DIV_L);
    run_op("modu_5_0",   3'd7, 32'h00000005, 32'h00000000, 32'h00000005, DIV_L);
    run_op("div_-5_0",   3'd4, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, DIV_L);
    run_op("mod_-5_0",   3'd5, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, DIV_L);
    run_op("rsvd",       3'd3, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1);
    run_op("divu_3_9",   3'd6, 32'h00000003, 32'h00000009, 32'h00000000, FAST_LAT);
    run_op("modu_3_9",   3'd7, 32'h00000003, 32'h00000009, 32'h00000003, FAST_LAT);
    run_op("div_-3_9",   3'd4, 32'hFFFFFFFD, 32'h00000009, 32'h00000000, FAST_LAT);
    run_op("mod_-3_9",   3'd5, 32'hFFFFFFFD, 32'h00000009, 32'hFFFFFFFD, FAST_LAT);

    // DIV 100/3 killed at T+10; unit idle at T+11, result keeps 0xFFFFFFFD
    @(negedge clk);
    start = 1'b1; op = 3'd4; src1 = 32'd100; src2 = 32'd3;
    no_done = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) no_done = 1'b0;
    end
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    if (done) no_done = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_stall", 32'(stall_req), 32'd0);
    chk("flush_no_done", 32'(no_done), 32'd1);
    chk("flush_result", result, 32'hFFFFFFFD);
    run_op("mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12, MUL_L);

    // start and flush together: not accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd0; src1 = 32'd2; src2 = 32'd2;
    #1;
    chk("sf_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("sf_busy", 32'(busy), 32'd0);
    chk("sf_done", 32'(done), 32'd0);
    chk("sf_result", result, 32'd12);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 3'd4; src1 = 32'd100; src2 = 32'd3;
    repeat (5) @(negedge clk);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("div_100_3", 3'd4, 32'd100, 32'd3, 32'd33, DIV_L);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
